// File: rtl/dmem_wbuf_pkg.sv
// Shared data-memory constants: default widths and SRAM port polarities.
// Also carries the write-buffer controller state type.
package dmem_wbuf_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    localparam logic CEN_ON = 1'b0;
    localparam logic WEN_WR = 1'b0;
    localparam logic OEN_ON = 1'b0;

    typedef enum logic [1:0] {
        WB_EMPTY,
        WB_PARTIAL,
        WB_FULL
    } wb_state_e;

endpackage

// File: rtl/dmem_wb_fifo.sv
// Write-through FIFO: push/pop, occupancy, controller FSM and
// the valid/ready head presented to the mirror bus.
module dmem_wb_fifo
    import dmem_wbuf_pkg::*;
#(
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          wb_ready,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [LW-1:0] level,
    output logic          full
);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] lvl_q;
    logic [LW-1:0] lvl_d;
    wb_state_e     state_q;
    wb_state_e     state_d;
    logic          pop;
    logic          accept;

    assign pop    = wb_valid & wb_ready;
    // A full buffer can still take a push when the head leaves this edge.
    assign accept = push & ((state_q != WB_FULL) | pop);
    assign lvl_d  = lvl_q + LW'(accept) - LW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lvl_q   <= '0;
            state_q <= WB_EMPTY;
        end else begin
            if (accept) begin
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            lvl_q   <= lvl_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_EMPTY: begin
                if (accept) state_d = WB_PARTIAL;
            end
            WB_PARTIAL: begin
                if (lvl_d == LW'(DEPTH)) state_d = WB_FULL;
                else if (lvl_d == '0)    state_d = WB_EMPTY;
            end
            WB_FULL: begin
                if (pop && !accept) state_d = WB_PARTIAL;
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    assign wb_valid = (state_q != WB_EMPTY);
    assign full     = (state_q == WB_FULL);
    assign level    = lvl_q;
    assign wb_addr  = wb_valid ? addr_q[rd_ptr] : '0;
    assign wb_data  = wb_valid ? data_q[rd_ptr] : '0;

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory behind the core's SRAM port, mirroring every store
// into a non-stalling write buffer with drop accounting.
module dmem_wbuf
    import dmem_wbuf_pkg::*;
#(
    parameter int ADDR_W   = dmem_wbuf_pkg::ADDR_W,
    parameter int DATA_W   = dmem_wbuf_pkg::DATA_W,
    parameter int WB_DEPTH = 4,
    parameter int CNT_W    = 8,
    localparam int LW      = $clog2(WB_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [LW-1:0]     wb_level,
    output logic              wb_overflow,
    output logic [CNT_W-1:0]  wb_drop_cnt
);

    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];
    logic              is_store;
    logic              is_load;
    logic              fifo_full;
    logic              drop;

    assign is_store = (CEN == CEN_ON) && (WEN == WEN_WR);
    assign is_load  = (CEN == CEN_ON) && (WEN != WEN_WR) && (OEN == OEN_ON);

    assign ReadDataMem = is_load ? mem[A] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (is_store) begin
            mem[A] <= Data2Mem;
        end
    end

    dmem_wb_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (WB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (is_store),
        .push_addr (A),
        .push_data (Data2Mem),
        .wb_ready  (wb_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .level     (wb_level),
        .full      (fifo_full)
    );

    // Full implies a valid head, so only a same-edge pop saves the store.
    assign drop = is_store & fifo_full & ~wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_overflow <= 1'b0;
            wb_drop_cnt <= '0;
        end else if (drop) begin
            wb_overflow <= 1'b1;
            if (wb_drop_cnt != '1) begin
                wb_drop_cnt <= wb_drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule
